// File: rtl/biquad8_coeff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | biquad8_coeff_loader: replays a local coefficient table as WISHBONE      |
// | single writes into a biquad8 target, optionally followed by an update.   |
// | Option macro: BIQUAD8_LOADER_TIMEOUT_EN (response timeout, retry limit). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module biquad8_coeff_loader #(
    parameter int NENTRY     = 32,
    parameter int AW         = $clog2(NENTRY),
    parameter int GAP_CYCLES = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          tbl_wr_i,
    input  logic [AW-1:0] tbl_adr_i,
    input  logic [22:0]   tbl_dat_i,
    input  logic [AW:0]   nentry_i,
    input  logic          update_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [6:0]    wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic [31:0]   wb_dat_i
);
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_FETCH  = 3'd1;
    localparam logic [2:0]  c_ST_WRITE  = 3'd2;
    localparam logic [2:0]  c_ST_GAP    = 3'd3;
    localparam logic [2:0]  c_ST_UPDATE = 3'd4;
    localparam logic [2:0]  c_ST_DONE   = 3'd5;
    localparam logic [3:0]  c_GAP       = 4'(GAP_CYCLES);
    localparam logic [AW:0] c_NENTRY    = (AW+1)'(NENTRY);
    localparam logic [AW:0] c_ONE       = (AW+1)'(1);

    logic [2:0]  state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [AW:0] nent_q, nent_d;
    logic        upd_q, upd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  gap_q, gap_d;
    logic [22:0] rd_q;
    logic [22:0] mem_q [NENTRY];
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  rcnt_q, rcnt_d;
`endif

    logic [AW:0] w_nent;
    logic        w_resp;
    logic        w_last;
    logic        w_unused;

    assign w_nent   = (nentry_i > c_NENTRY) ? c_NENTRY : nentry_i;
    assign w_resp   = cyc_q & (wb_ack_i | wb_err_i | wb_rty_i);
    assign w_last   = ((ptr_q + c_ONE) == nent_q);
    assign w_unused = ^wb_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (tbl_wr_i && !busy_q)
            mem_q[tbl_adr_i] <= tbl_dat_i;
        if (state_q == c_ST_FETCH)
            rd_q <= mem_q[ptr_q[AW-1:0]];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= c_ST_IDLE;
            ptr_q   <= '0;
            nent_q  <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            gap_q   <= '0;
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
            tmo_q   <= '0;
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            nent_q  <= nent_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            gap_q   <= gap_d;
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
            tmo_q   <= tmo_d;
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        nent_d  = nent_q;
        upd_d   = upd_q;
        busy_d  = busy_q;
        err_d   = err_q;
        gap_d   = gap_q;
        done_d  = (state_q == c_ST_DONE);
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
        tmo_d   = cyc_q ? (tmo_q + 16'd1) : 16'd0;
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (start_i) begin
                    nent_d = w_nent;
                    upd_d  = update_i;
                    ptr_d  = '0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
                    rcnt_d = '0;
`endif
                    if (w_nent != '0)
                        state_d = c_ST_FETCH;
                    else if (update_i)
                        state_d = c_ST_UPDATE;
                    else
                        state_d = c_ST_DONE;
                end
            end
            c_ST_FETCH: state_d = c_ST_WRITE;
            c_ST_WRITE, c_ST_UPDATE: begin
                if (cyc_q) begin
                    if (wb_err_i) begin
                        err_d   = 1'b1;
                        state_d = c_ST_DONE;
                    end else if (wb_ack_i) begin
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
                        rcnt_d = '0;
`endif
                        if (state_q == c_ST_UPDATE) begin
                            state_d = c_ST_DONE;
                        end else begin
                            ptr_d = ptr_q + c_ONE;
                            if (w_last)
                                state_d = upd_q ? c_ST_UPDATE : c_ST_DONE;
                            else if (c_GAP == 4'd0)
                                state_d = c_ST_FETCH;
                            else begin
                                state_d = c_ST_GAP;
                                gap_d   = c_GAP - 4'd1;
                            end
                        end
                    end else if (wb_rty_i) begin
                        if (c_GAP == 4'd0)
                            state_d = (state_q == c_ST_UPDATE) ? c_ST_UPDATE : c_ST_FETCH;
                        else begin
                            state_d = c_ST_GAP;
                            gap_d   = c_GAP - 4'd1;
                        end
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
                        rcnt_d = rcnt_q + 8'd1;
                        if (rcnt_q == 8'hFF) begin
                            err_d   = 1'b1;
                            state_d = c_ST_DONE;
                        end
                    end else if (tmo_q == 16'hFFFF) begin
                        err_d   = 1'b1;
                        state_d = c_ST_DONE;
`endif
                    end
                end
            end
            c_ST_GAP: begin
                // ptr only reaches nent once every entry is acked, so a retried update lands here
                if (gap_q == 4'd0)
                    state_d = (ptr_q == nent_q) ? c_ST_UPDATE : c_ST_FETCH;
                else
                    gap_d = gap_q - 4'd1;
            end
            c_ST_DONE: begin
                busy_d  = 1'b0;
                state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
        // A response always drops cyc for at least one cycle, even on WRITE->UPDATE
        cyc_d = ((state_d == c_ST_WRITE) || (state_d == c_ST_UPDATE)) && !w_resp;
    end

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        if (cyc_q) begin
            wb_sel_o = 4'hF;
            if (state_q == c_ST_UPDATE) begin
                wb_adr_o = 7'h00;
                wb_dat_o = 32'h0000_0001;
            end else begin
                wb_adr_o = {rd_q[22:18], 2'b00};
                wb_dat_o = {14'b0, rd_q[17:0]};
            end
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
endmodule
`default_nettype wire
